// File: rtl/axi_pkg.sv
// Shared AXI read-master constants and FSM state type.
// Imported by axi_rd_master and by the optional axi_rd_checker.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_e;

   // Beats are 8 bytes wide, so every burst starts on an 8-byte boundary.
   function automatic logic [31:0] align_8b(input logic [31:0] addr);
      return {addr[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/axi_rd_checker.sv
// Sticky R-channel protocol/response checker for axi_rd_master.
// Compiled only when AXI_RD_MST_CHECK_EN is defined; otherwise this file is empty.
`ifdef AXI_RD_MST_CHECK_EN
module axi_rd_checker
   import axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       r_hs,
   input  logic [3:0] rid,
   input  logic [1:0] rresp,
   input  logic       rlast,
   input  logic [7:0] beat_cnt,
   input  logic [7:0] burst_len,
   output logic       err
);

   logic err_q, err_d;
   logic bad_beat;

   // rlast must coincide exactly with the beat whose index equals arlen.
   assign bad_beat = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID) ||
                     (rlast != (beat_cnt == burst_len));

   always_comb begin
      err_d = err_q;
      if (r_hs && bad_beat) err_d = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign err = err_q;

endmodule
`endif

// File: rtl/axi_rd_master.sv
// Single-outstanding AXI4 INCR read master: one AR per request, beats streamed out with 1-cycle latency.
// Optional sticky protocol checker enabled by defining AXI_RD_MST_CHECK_EN.
module axi_rd_master
   import axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_len,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        data_valid,
   output logic [63:0] data_out,
   output logic        data_last,
   output logic        err
);

   rd_state_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [63:0] data_q, data_d;
   logic        dvalid_q, dvalid_d;
   logic        dlast_q, dlast_d;
   logic        r_hs;

   assign req_ready = (state_q == ST_IDLE);
   assign arvalid   = (state_q == ST_ADDR);
   assign rready    = (state_q == ST_DATA);
   assign r_hs      = rvalid && rready;

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      dvalid_d = 1'b0;
      dlast_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_ADDR;
               addr_d  = align_8b(req_addr);
               len_d   = req_len;
            end
         end
         ST_ADDR: begin
            if (arready) begin
               state_d = ST_DATA;
               cnt_d   = 8'd0;
            end
         end
         ST_DATA: begin
            if (rvalid) begin
               dvalid_d = 1'b1;
               data_d   = rdata;
               dlast_d  = rlast;
               // Hold at 255 so a 256-beat burst never wraps the index.
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               // Only rlast ends the burst; the count is advisory.
               if (rlast) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         dlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
         dlast_q  <= dlast_d;
      end
   end

   assign araddr     = addr_q;
   assign arlen      = len_q;
   assign arid       = AXI_ID;
   assign arsize     = AXI_SIZE_8B;
   assign arburst    = AXI_BURST_INCR;
   assign data_valid = dvalid_q;
   assign data_out   = data_q;
   assign data_last  = dlast_q;

`ifdef AXI_RD_MST_CHECK_EN
   axi_rd_checker #(
      .AXI_ID (AXI_ID)
   ) u_checker (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .r_hs      (r_hs),
      .rid       (rid),
      .rresp     (rresp),
      .rlast     (rlast),
      .beat_cnt  (cnt_q),
      .burst_len (len_q),
      .err       (err)
   );
`else
   logic unused_ok;
   assign unused_ok = ^{rid, rresp, cnt_q, r_hs, req_addr[2:0]};
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_master.sv
// Randomized self-checking bench for axi_rd_master acting as the AXI slave.
// Expected beats come from a queue-free per-burst model of what the slave sent.
module tb_axi_rd_master;

   localparam logic [3:0] ID = 4'h5;

   logic        aclk;
   logic        aresetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        data_valid;
   logic [63:0] data_out;
   logic        data_last;
   logic        err;

   int          n_vec;
   int          n_err;
   bit          err_exp;
   bit          use_fixed;

   axi_rd_master #(.AXI_ID(ID)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .araddr     (araddr),
      .arid       (arid),
      .arlen      (arlen),
      .arsize     (arsize),
      .arburst    (arburst),
      .arvalid    (arvalid),
      .arready    (arready),
      .rid        (rid),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .rvalid     (rvalid),
      .rready     (rready),
      .data_valid (data_valid),
      .data_out   (data_out),
      .data_last  (data_last),
      .err        (err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_rready"}, rready, 0);
      check({tag, "_dvalid"}, data_valid, 0);
      check({tag, "_dlast"}, data_last, 0);
      check({tag, "_dout"}, data_out, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_araddr"}, araddr, 0);
      check({tag, "_arlen"}, arlen, 0);
   endtask

   task automatic idle_check(input string tag);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_rready"}, rready, 0);
      check({tag, "_dvalid"}, data_valid, 0);
      check({tag, "_err"}, err, err_exp);
   endtask

   // Asynchronous reset asserted between clock edges, checked before the next edge.
   task automatic do_reset();
      #2 aresetn = 1'b0;
      #1 check_reset_values("rst");
      err_exp = 1'b0;
      req_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      tick();
      check("rst_held_ready", req_ready, 1);
      aresetn = 1'b1;
      tick();
      idle_check("post_rst");
   endtask

   // Output expected at a DATA-phase negedge given whether the previous edge carried a beat.
   task automatic check_out(input bit pend, input logic [63:0] pd, input bit pl);
      check("rready", rready, 1);
      check("arvalid_low", arvalid, 0);
      check("dvalid", data_valid, pend);
      if (pend) begin
         check("dout", data_out, pd);
         check("dlast", data_last, pl);
      end
      check("err", err, err_exp);
   endtask

   // Starts at a negedge with the DUT idle; returns at the negedge showing the final data_valid.
   task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                            input int gap_pct, input int bad_resp_beat, input int early_last,
                            input int abort_beat);
      int          last_beat;
      int          ng;
      bit          pend;
      logic [63:0] pd;
      bit          pl;
      logic [63:0] d;
      bit          bad;
      check("req_ready", req_ready, 1);
      req_valid = 1'b1; req_addr = addr; req_len = len;
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom);
      for (int c = 0; c <= ar_delay; c++) begin
         check("arvalid", arvalid, 1);
         check("araddr", araddr, {addr[31:3], 3'b000});
         check("arlen", arlen, len);
         check("arid", arid, ID);
         check("arsize", arsize, 3'b011);
         check("arburst", arburst, 2'b01);
         check("req_ready_busy", req_ready, 0);
         check("rready_addr", rready, 0);
         check("dvalid_addr", data_valid, 0);
         check("err_addr", err, err_exp);
         rvalid = 1'($urandom_range(0, 1)); rdata = {$urandom, $urandom}; rlast = 1'b1;
         arready = (c == ar_delay);
         tick();
      end
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      last_beat = (early_last >= 0) ? early_last : int'(len);
      pend = 1'b0; pd = '0; pl = 1'b0;
      for (int b = 0; b <= last_beat; b++) begin
         ng = 0;
         if (gap_pct < 0) ng = (b > 0) ? 1 : 0;
         else while (ng < 3 && $urandom_range(0, 99) < gap_pct) ng++;
         for (int g = 0; g < ng; g++) begin
            check_out(pend, pd, pl);
            pend = 1'b0;
            rvalid = 1'b0; rdata = {$urandom, $urandom}; rlast = 1'($urandom_range(0, 1));
            tick();
         end
         check_out(pend, pd, pl);
         d = use_fixed ? 64'hDEAD_BEEF_CAFE_F00D : {$urandom, $urandom};
         rvalid = 1'b1; rdata = d; rid = ID; rlast = (b == last_beat);
         rresp = (b == bad_resp_beat) ? 2'b10 : 2'b00;
         if (b == abort_beat) begin
            rlast = 1'b0;
            do_reset();
            for (int s = 0; s < 4; s++) begin
               rvalid = 1'b1; rdata = {$urandom, $urandom}; rlast = 1'($urandom_range(0, 1));
               tick();
               idle_check("stray");
               check("stray_araddr", araddr, 0);
            end
            rvalid = 1'b0; rlast = 1'b0;
            return;
         end
         bad = (b == bad_resp_beat) || (rlast != (b == int'(len)));
         tick();
`ifdef AXI_RD_MST_CHECK_EN
         if (bad) err_exp = 1'b1;
`else
         if (bad) err_exp = 1'b0;
`endif
         pend = 1'b1; pd = d; pl = (b == last_beat);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      check("final_dvalid", data_valid, 1);
      check("final_dout", data_out, pd);
      check("final_dlast", data_last, 1);
      check("final_req_ready", req_ready, 1);
      check("final_rready", rready, 0);
      check("final_err", err, err_exp);
   endtask

   initial begin
      logic [7:0] rl;
      n_vec = 0; n_err = 0; err_exp = 1'b0; use_fixed = 1'b0;
      aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; arready = 1'b0;
      rid = ID; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      tick();
      check_reset_values("init");
      check("init_req_ready", req_ready, 1);
      aresetn = 1'b1;
      tick();
      idle_check("init_idle");

      // Unaligned address, AR accepted after two wait cycles.
      run_burst(32'h8000_0004, 8'd3, 2, 0, -1, -1, -1);
      // Single-beat burst with known data, chained back-to-back.
      use_fixed = 1'b1;
      run_burst(32'h0000_1000, 8'd0, 0, 0, -1, -1, -1);
      use_fixed = 1'b0;
      // rvalid toggling every other cycle.
      run_burst(32'h1234_5678, 8'd7, 1, -1, -1, -1, -1);
      tick();
      idle_check("gap");
      // Reset during the second of four beats.
      run_burst(32'h4000_0010, 8'd3, 0, 0, -1, -1, 1);
      // Error response on beat 0.
      run_burst(32'h0000_2000, 8'd3, 0, 20, 0, -1, -1);
      tick();
      idle_check("err_sticky");
      do_reset();
      // Early rlast at beat index 1 of a four-beat burst: burst still ends.
      run_burst(32'h0000_3000, 8'd3, 0, 0, -1, 1, -1);
      tick();
      idle_check("early_last_sticky");
      do_reset();
      // Longest burst.
      run_burst(32'hFFFF_FFF8, 8'd255, 0, 10, -1, -1, -1);

      for (int i = 0; i < 25; i++) begin
         rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 12));
         run_burst($urandom, rl, $urandom_range(0, 3), $urandom_range(0, 50), -1, -1, -1);
         if ($urandom_range(0, 2) == 0) begin
            tick();
            idle_check("rand_idle");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_rd_master.md
AXI_RD_MASTER -- requirements
Module: axi_rd_master

Interface
REQ-001 The block SHALL have parameter AXI_ID, default 4'h0, the fixed ID driven on arid and expected on rid.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports as listed below.
- aclk  input  1  sole clock; all logic on posedge
- aresetn  input  1  asynchronous active-low reset
- req_valid  input  1  refill request valid
- req_ready  output  1  block idle, request accepted when req_valid=1
- req_addr  input  32  burst start address; bits [2:0] ignored and driven 0
- req_len  input  8  beats minus one (0..255)
- araddr  output  32  AXI read address
- arid  output  4  constant AXI_ID
- arlen  output  8  registered req_len
- arsize  output  3  constant 3'b011 (8 bytes)
- arburst  output  2  constant 2'b01 (INCR)
- arvalid  output  1  AR channel valid
- arready  input  1  AR channel ready
- rid  input  4  read data ID
- rdata  input  64  read data beat
- rresp  input  2  read response
- rlast  input  1  final beat marker
- rvalid  input  1  R channel valid
- rready  output  1  R channel ready
- data_valid  output  1  one-cycle pulse per received beat
- data_out  output  64  captured beat data
- data_last  output  1  high with data_valid on the final beat
- err  output  1  sticky protocol or response error (see Configuration)

Function
REQ-003 The FSM SHALL have three states, IDLE, ADDR and DATA: IDLE->ADDR on req_valid&&req_ready; ADDR->DATA on arvalid&&arready; DATA->IDLE on rvalid&&rready&&rlast.
REQ-004 req_ready SHALL be 1 exactly in IDLE; accepting a request SHALL register req_addr (with [2:0] cleared) and req_len.
REQ-005 arvalid SHALL be 1 exactly in ADDR, beginning the cycle after acceptance, with araddr and arlen stable until the handshake; arvalid SHALL NOT depend combinationally on arready and SHALL NOT drop before arready.
REQ-006 rready SHALL be 1 exactly in DATA; rvalid SHALL be ignored in every other state.
REQ-007 Each R handshake SHALL produce data_valid=1 and data_out=rdata on the following cycle, giving 1-cycle latency, with data_last equal to the registered rlast.
REQ-008 An 8-bit beat counter SHALL clear on AR handshake and increment on each R handshake; the burst SHALL end on rlast only, regardless of the count.
REQ-009 A new request SHALL be accepted in the cycle the final data_valid is high, giving back-to-back bursts with no dead cycle beyond the AR phase.
REQ-010 With req_len=0, a single beat SHALL complete the burst; with req_len=255, the counter SHALL reach 255 without wrapping before rlast.
REQ-011 rdata SHALL be passed through without modification or byte-lane masking.

Reset
REQ-012 Asserting aresetn low at any time, including mid-burst, SHALL immediately force IDLE, arvalid=0, rready=0, data_valid=0, data_last=0, data_out=0, err=0, araddr=0, arlen=0 and counter=0, with req_ready=1 after release.
REQ-013 After reset release, the block SHALL drop any in-flight beats and SHALL NOT resume the aborted burst.

Configuration
REQ-014 When macro AXI_RD_MST_CHECK_EN is defined, err SHALL set on any R handshake with rresp!=2'b00, rid!=AXI_ID, rlast=1 while counter!=arlen, or rlast=0 while counter==arlen; err SHALL stay high until reset and SHALL NOT alter data flow.
REQ-015 When AXI_RD_MST_CHECK_EN is undefined, err SHALL be tied 0 and no checker logic SHALL be present.

Structure
REQ-016 Package axi_pkg SHALL hold AXI_BURST_INCR, AXI_SIZE_8B, AXI_RESP_OKAY and the FSM state enum.
REQ-017 The checker SHALL be the sub-module axi_rd_checker, instantiated only under AXI_RD_MST_CHECK_EN.

Verification
REQ-018 req_addr=0x80000004, req_len=3, arready delayed 2 cycles -> araddr=0x80000000, arlen=3, arvalid held for 3 cycles, 4 data_valid pulses with data_last on the 4th, err=0.
REQ-019 req_len=0, slave returns rdata=0xDEADBEEF_CAFEF00D with rlast -> a single data_valid, data_out=0xDEADBEEFCAFEF00D, data_last=1.
REQ-020 Two queued requests, where the second has req_valid held high -> second araddr appears 1 cycle after the first burst's final data_valid.
REQ-021 rvalid toggling every other cycle across a req_len=7 burst -> exactly 8 pulses in order, no duplicates.
REQ-022 aresetn=0 during beat 2 of 4 -> all outputs are at reset values in the same cycle, and after release stray rvalid produces no data_valid.
REQ-023 With AXI_RD_MST_CHECK_EN defined, rresp=2'b10 on beat 1 or an early rlast at beat 2 of 4 -> err=1 and stays 1; without the macro, err=0.
